// File: rtl/block_mem_responder_if.sv
// Cache/memory request-response signals for block_mem_responder.
// The shared block data bus dataM is a plain inout on the responder.
interface block_mem_responder_if #(
   parameter int WORD_SIZE = 16
);
   logic                 readM;
   logic                 writeM;
   logic [WORD_SIZE-1:0] addressM;
   logic                 input_readyM;
   logic                 doneM;
   logic                 busy;

   modport master (
      output readM,
      output writeM,
      output addressM,
      input  input_readyM,
      input  doneM,
      input  busy
   );

   modport slave (
      input  readM,
      input  writeM,
      input  addressM,
      output input_readyM,
      output doneM,
      output busy
   );
endinterface

// File: rtl/block_mem_responder.sv
// Memory-side responder: fixed-latency 4-word block reads/writes on the cache bus.
// Define MEM_WORD_WRITE_EN to make a write commit only the addressed word (cache bypass mode).
module block_mem_responder #(
   parameter int WORD_SIZE = 16,
   parameter int READ_SIZE = 4*WORD_SIZE,
   parameter int LATENCY   = 4,
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   block_mem_responder_if.slave bus,
   inout  wire  [READ_SIZE-1:0] dataM
);
   localparam int ROW_BITS = ADDR_BITS - 2;
   localparam int ROWS     = 1 << ROW_BITS;
   localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      WR_WAIT = 3'd2,
      RD_RESP = 3'd3,
      WR_RESP = 3'd4
   } state_t;

   state_t                state_reg;
   state_t                state_next;
   logic [7:0]            count_reg;
   logic [7:0]            count_next;
   logic [ROW_BITS-1:0]   row_reg;
   logic [ROW_BITS-1:0]   row_next;
   logic                  count_zero;
   logic                  rd_fire;
   logic                  wr_fire;
   logic                  drive_en;
   logic [READ_SIZE-1:0]  rd_block;

   assign count_zero = (count_reg == 8'd0);

   // Storage is accessed at the edge leaving WAIT; gating with reset_n drops a pending write.
   assign rd_fire = reset_n && (state_reg == RD_WAIT) && bus.readM  && count_zero;
   assign wr_fire = reset_n && (state_reg == WR_WAIT) && bus.writeM && count_zero;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         count_reg <= '0;
         row_reg   <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         row_reg   <= row_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      row_next   = row_reg;
      case (state_reg)
         IDLE: begin
            if (bus.readM) begin
               state_next = RD_WAIT;
               count_next = COUNT_LOAD;
               row_next   = bus.addressM[ADDR_BITS-1:2];
            end else if (bus.writeM) begin
               state_next = WR_WAIT;
               count_next = COUNT_LOAD;
               row_next   = bus.addressM[ADDR_BITS-1:2];
            end
         end
         RD_WAIT: begin
            if (!bus.readM)
               state_next = IDLE;
            else if (count_zero)
               state_next = RD_RESP;
            else
               count_next = count_reg - 8'd1;
         end
         WR_WAIT: begin
            if (!bus.writeM)
               state_next = IDLE;
            else if (count_zero)
               state_next = WR_RESP;
            else
               count_next = count_reg - 8'd1;
         end
         RD_RESP: state_next = IDLE;
         WR_RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The read response never fights an initiator that is still holding writeM.
   always_comb begin
      bus.input_readyM = 1'b0;
      bus.doneM        = 1'b0;
      bus.busy         = 1'b1;
      drive_en         = 1'b0;
      case (state_reg)
         IDLE:    bus.busy = 1'b0;
         RD_RESP: begin
            bus.input_readyM = 1'b1;
            drive_en         = !bus.writeM;
         end
         WR_RESP: bus.doneM = 1'b1;
         default: ;
      endcase
   end

`ifdef MEM_WORD_WRITE_EN
   logic [1:0] lane_reg;

   always_ff @(posedge clk) begin
      if (!reset_n)
         lane_reg <= '0;
      else if ((state_reg == IDLE) && (bus.readM || bus.writeM))
         lane_reg <= bus.addressM[1:0];
   end

   logic unused_bits;
   assign unused_bits = ^{bus.addressM[WORD_SIZE-1:ADDR_BITS], dataM[READ_SIZE-1:WORD_SIZE]};
`else
   logic unused_bits;
   assign unused_bits = ^{bus.addressM[WORD_SIZE-1:ADDR_BITS], bus.addressM[1:0]};
`endif

   // One bank per word lane; an aligned block touches the same row in all four banks.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bank
         logic [WORD_SIZE-1:0] mem [ROWS];
         logic [WORD_SIZE-1:0] rd_word_reg;
         logic [WORD_SIZE-1:0] wr_word;
         logic                 we;

`ifdef MEM_WORD_WRITE_EN
         assign we      = wr_fire && (lane_reg == 2'(gi));
         assign wr_word = dataM[WORD_SIZE-1:0];
`else
         assign we      = wr_fire;
         assign wr_word = dataM[gi*WORD_SIZE +: WORD_SIZE];
`endif

         always_ff @(posedge clk) begin
            if (we)
               mem[row_reg] <= wr_word;
            if (rd_fire)
               rd_word_reg <= mem[row_reg];
         end

         assign rd_block[gi*WORD_SIZE +: WORD_SIZE] = rd_word_reg;
      end
   endgenerate

   assign dataM = drive_en ? rd_block : {READ_SIZE{1'bz}};

endmodule

// File: tb/tb_block_mem_responder.sv
// Self-checking bench for block_mem_responder: table vectors, corner sequences, random traffic.
module tb_block_mem_responder;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rd_req = 1'b0;
   logic        wr_req = 1'b0;
   logic        tb_drv = 1'b0;
   logic        sel = 1'b0;     // 0: LATENCY=4 instance, 1: LATENCY=1 instance
   logic [15:0] addr = '0;
   logic [63:0] tb_data = '0;
   wire  [63:0] data0;
   wire  [63:0] data1;

   int total = 0;
   int bad = 0;

   block_mem_responder_if #(.WORD_SIZE(16)) if0 ();
   block_mem_responder_if #(.WORD_SIZE(16)) if1 ();

   assign if0.readM    = rd_req & ~sel;
   assign if0.writeM   = wr_req & ~sel;
   assign if0.addressM = addr;
   assign if1.readM    = rd_req & sel;
   assign if1.writeM   = wr_req & sel;
   assign if1.addressM = addr;
   assign data0 = (tb_drv && !sel) ? tb_data : {64{1'bz}};
   assign data1 = (tb_drv &&  sel) ? tb_data : {64{1'bz}};

   block_mem_responder #(.WORD_SIZE(16), .LATENCY(4), .ADDR_BITS(10)) dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if0),
      .dataM   (data0)
   );

   block_mem_responder #(.WORD_SIZE(16), .LATENCY(1), .ADDR_BITS(10)) dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if1),
      .dataM   (data1)
   );

   logic        ir_m, done_m, busy_m;
   logic [63:0] bus_m;
   assign ir_m   = sel ? if1.input_readyM : if0.input_readyM;
   assign done_m = sel ? if1.doneM        : if0.doneM;
   assign busy_m = sel ? if1.busy         : if0.busy;
   assign bus_m  = sel ? data1            : data0;

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // Reference storage for the LATENCY=4 instance: word array plus "has been written" flags.
   logic [15:0] ref_mem [1024];
   bit          ref_known [1024];

   function automatic void ref_write(input logic [15:0] a, input logic [63:0] d);
      int w;
`ifdef MEM_WORD_WRITE_EN
      w = int'(a) % 1024;
      ref_mem[w]   = d[15:0];
      ref_known[w] = 1'b1;
`else
      for (int i = 0; i < 4; i++) begin
         w = ((int'(a) & 'hFFFC) + i) % 1024;
         ref_mem[w]   = d[i*16 +: 16];
         ref_known[w] = 1'b1;
      end
`endif
   endfunction

   function automatic logic [63:0] ref_read(input logic [15:0] a, output logic [63:0] mask);
      int w;
      logic [63:0] d;
      d    = '0;
      mask = '0;
      for (int i = 0; i < 4; i++) begin
         w = ((int'(a) & 'hFFFC) + i) % 1024;
         if (ref_known[w]) begin
            d[i*16 +: 16]    = ref_mem[w];
            mask[i*16 +: 16] = 16'hFFFF;
         end
      end
      return d;
   endfunction

   function automatic bit released();
      return (bus_m === 64'd0) || $isunknown(bus_m);
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // One request from a negedge until the cycle after its response; ends on a negedge in IDLE.
   task automatic txn(input bit rd, input logic [15:0] a, input logic [63:0] wd,
                      input logic [63:0] want, input logic [63:0] mask, input string name);
      int lat;
      int hit;
      logic [63:0] got;
      lat = sel ? 1 : 4;
      hit = -1;
      got = '0;
      addr = a;
      if (rd) begin
         rd_req = 1'b1;
      end else begin
         wr_req  = 1'b1;
         tb_data = wd;
         tb_drv  = 1'b1;
      end
      for (int j = 0; j < lat + 8 && hit < 0; j++) begin
         @(negedge clk);
         if (j == 0) check({name, "_busy"}, 64'(busy_m), 64'd1);
         if (rd && j == lat - 1) check({name, "_relpre"}, 64'(released()), 64'd1);
         if (rd ? ir_m : done_m) begin
            hit = j;
            got = bus_m;
         end
      end
      check({name, "_lat"}, 64'(hit), 64'(lat));
      if (rd && hit >= 0) check({name, "_data"}, got & mask, want & mask);
      if (!rd && !sel) ref_write(a, wd);
      rd_req = 1'b0;
      wr_req = 1'b0;
      tb_drv = 1'b0;
      @(negedge clk);
      check({name, "_idle"}, {61'd0, busy_m, ir_m, done_m}, 64'd0);
      if (rd) check({name, "_relpost"}, 64'(released()), 64'd1);
      $display("txn %s %s addr=%h lat=%0d data=%h", name, rd ? "RD" : "WR", a, hit, rd ? got : wd);
   endtask

   task automatic preload(input logic [15:0] base, input logic [63:0] d);
`ifdef MEM_WORD_WRITE_EN
      for (int i = 0; i < 4; i++)
         txn(1'b0, base + 16'(i), {48'd0, d[i*16 +: 16]}, '0, '0, "preload");
`else
      txn(1'b0, base, d, '0, '0, "preload");
`endif
   endtask

   typedef struct {
      bit          rd;
      logic [15:0] a;
      logic [63:0] wd;
      logic [63:0] want;
      string       name;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int first_rd;
      int first_wr;
      bit seen;
      logic [63:0] m;
      logic [63:0] e;

      vecs[0] = '{1'b1, 16'h0042, 64'd0, 64'h4444_3333_2222_1111, "rd_0042"};
      vecs[1] = '{1'b1, 16'h0043, 64'd0, 64'h4444_3333_2222_1111, "rd_0043"};
      vecs[2] = '{1'b0, 16'h0081, 64'hDDDD_CCCC_BBBB_AAAA, 64'd0, "wr_0081"};
`ifdef MEM_WORD_WRITE_EN
      vecs[3] = '{1'b1, 16'h0080, 64'd0, 64'h0808_0707_AAAA_0505, "rd_0080"};
`else
      vecs[3] = '{1'b1, 16'h0080, 64'd0, 64'hDDDD_CCCC_BBBB_AAAA, "rd_0080"};
`endif
      vecs[4] = '{1'b1, 16'hFFFE, 64'd0, 64'hF00D_BEEF_CAFE_1234, "rd_fffe"};
      vecs[5] = '{1'b0, 16'h0041, 64'h9999_8888_7777_6666, 64'd0, "wr_0041"};
`ifdef MEM_WORD_WRITE_EN
      vecs[6] = '{1'b1, 16'h0040, 64'd0, 64'h4444_3333_6666_1111, "rd_0040"};
`else
      vecs[6] = '{1'b1, 16'h0040, 64'd0, 64'h9999_8888_7777_6666, "rd_0040"};
`endif

      // Reset state, both during and just after reset.
      repeat (3) @(negedge clk);
      check("rst_outs0", {61'd0, if0.busy, if0.input_readyM, if0.doneM}, 64'd0);
      check("rst_outs1", {61'd0, if1.busy, if1.input_readyM, if1.doneM}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_outs", {61'd0, busy_m, ir_m, done_m}, 64'd0);
      check("post_rst_rel", 64'(released()), 64'd1);

      preload(16'h0040, 64'h4444_3333_2222_1111);
      preload(16'h0080, 64'h0808_0707_0606_0505);
      preload(16'h03FC, 64'hF00D_BEEF_CAFE_1234);
      preload(16'h0100, 64'h0104_0103_0102_0101);

      for (int v = 0; v < 7; v++)
         txn(vecs[v].rd, vecs[v].a, vecs[v].wd, vecs[v].want, {64{1'b1}}, vecs[v].name);

      // Read and write together: read first, write taken at the second edge after the read pulse.
      addr = 16'h0044;
      rd_req = 1'b1;
      wr_req = 1'b1;
      tb_data = 64'h5A5A_4B4B_3C3C_2D2D;
      tb_drv = 1'b1;
      first_rd = -1;
      first_wr = -1;
      for (int c = 0; c < 20 && first_wr < 0; c++) begin
         @(negedge clk);
         if (ir_m && first_rd < 0) begin
            first_rd = c;
            rd_req = 1'b0;
         end
         if (done_m) begin
            first_wr = c;
            wr_req = 1'b0;
            tb_drv = 1'b0;
         end
      end
      check("both_rd_at", 64'(first_rd), 64'd4);
      check("both_wr_at", 64'(first_wr), 64'd10);
      ref_write(16'h0044, 64'h5A5A_4B4B_3C3C_2D2D);
      @(negedge clk);
      check("both_idle", {61'd0, busy_m, ir_m, done_m}, 64'd0);
      $display("txn both_high rd_at=%0d wr_at=%0d", first_rd, first_wr);
      e = ref_read(16'h0044, m);
      txn(1'b1, 16'h0044, '0, e, m, "both_readback");

      // Read abandoned during RD_WAIT.
      addr = 16'h0040;
      rd_req = 1'b1;
      seen = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy_m), 64'd1);
      if (ir_m) seen = 1'b1;
      @(negedge clk);
      if (ir_m) seen = 1'b1;
      rd_req = 1'b0;
      @(negedge clk);
      check("abort_idle", 64'(busy_m), 64'd0);
      repeat (8) begin
         @(negedge clk);
         if (ir_m) seen = 1'b1;
      end
      check("abort_noresp", 64'(seen), 64'd0);
      $display("txn abort addr=0040 resp_seen=%0d", seen);
      txn(1'b0, 16'h0048, 64'h1357_2468_ACE0_BDF1, '0, '0, "after_abort_wr");
      e = ref_read(16'h0048, m);
      txn(1'b1, 16'h0048, '0, e, m, "after_abort_rd");

      // Reset for one edge while a write to 0x0100 is waiting.
      addr = 16'h0100;
      wr_req = 1'b1;
      tb_data = 64'hDEAD_DEAD_DEAD_DEAD;
      tb_drv = 1'b1;
      seen = 1'b0;
      @(negedge clk);
      check("rstw_busy", 64'(busy_m), 64'd1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      wr_req = 1'b0;
      tb_drv = 1'b0;
      check("rstw_idle", {61'd0, busy_m, ir_m, done_m}, 64'd0);
      repeat (8) begin
         @(negedge clk);
         if (done_m) seen = 1'b1;
      end
      check("rstw_nodone", 64'(seen), 64'd0);
      $display("txn reset_during_write addr=0100 done_seen=%0d", seen);
      txn(1'b1, 16'h0100, '0, 64'h0104_0103_0102_0101, {64{1'b1}}, "rstw_readback");

      // LATENCY=1 instance with a wrapping address.
      sel = 1'b1;
      @(negedge clk);
      preload(16'hFBFC, 64'h7777_6666_5555_4444);
      txn(1'b1, 16'hFFFE, '0, 64'h7777_6666_5555_4444, {64{1'b1}}, "l1_rd_wrap");
      txn(1'b1, 16'h03FD, '0, 64'h7777_6666_5555_4444, {64{1'b1}}, "l1_rd_3fd");
      sel = 1'b0;
      @(negedge clk);

      // Random traffic against the reference storage.
      for (int n = 0; n < 60; n++) begin
         logic [15:0] ra;
         ra = 16'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) ra = ra | 16'hFC00;
         e = ref_read(ra, m);
         if (($urandom_range(0, 1) == 1) && (m != 64'd0))
            txn(1'b1, ra, '0, e, m, "rnd_rd");
         else
            txn(1'b0, ra, {$urandom, $urandom}, '0, '0, "rnd_wr");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
